// File: rtl/seq_trig_arm.sv
// Multi-channel "a ##DLY b" sequence detector with an arming FSM
// (match, ready, settle, match, arm) that gates a capture register.
module seq_trig_arm #(
    parameter int NCH    = 4,
    parameter int DLY    = 2,
    parameter int SETTLE = 5,
    parameter int W      = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] a,
    input  logic [NCH-1:0] b,
    input  logic           rdy,
    input  logic           clr,
    input  logic [W-1:0]   din,
    output logic [NCH-1:0] e,
    output logic           f,
    output logic [W-1:0]   h,
    output logic           enb,
    output logic [2:0]     state
);

    typedef enum logic [2:0] {
        ST_SEQ    = 3'd0,
        ST_GAP    = 3'd1,
        ST_RDY    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_TRIG   = 3'd4,
        ST_ARMP   = 3'd5,
        ST_ARMED  = 3'd6
    } state_t;

    // A zero-length settle still needs a legal counter width.
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [DLY-1:0][NCH-1:0]   sr_q, sr_d;
    logic [NCH-1:0]            e_q, e_d;
    logic                      f_q, f_d;
    logic                      enb_q, enb_d;
    logic [W-1:0]              h_q, h_d;
    logic [NCH-1:0]            match;
    logic                      any_match;

    assign match     = sr_q[DLY-1] & b;
    assign any_match = |match;

    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = a;
        for (int unsigned k = 1; k < DLY; k++) begin
            sr_d[k] = sr_q[k-1];
        end
        e_d = e_q ^ match;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f_d     = f_q;
        enb_d   = enb_q;
        h_d     = h_q;
        if (clr) begin
            state_d = ST_SEQ;
            enb_d   = 1'b0;
        end else begin
            if (enb_q) begin
                h_d = din;
            end
            case (state_q)
                ST_SEQ:    if (any_match) state_d = ST_GAP;
                ST_GAP:    state_d = ST_RDY;
                ST_RDY: begin
                    if (rdy) begin
                        f_d = ~f_q;
                        if (SETTLE == 0) begin
                            state_d = ST_TRIG;
                        end else begin
                            state_d = ST_SETTLE;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_TRIG;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_TRIG:   if (any_match) state_d = ST_ARMP;
                ST_ARMP: begin
                    state_d = ST_ARMED;
                    enb_d   = 1'b1;
                end
                ST_ARMED:  enb_d = 1'b1;
                default:   state_d = ST_SEQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SEQ;
            cnt_q   <= '0;
            sr_q    <= '0;
            e_q     <= '0;
            f_q     <= 1'b0;
            enb_q   <= 1'b0;
            h_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            e_q     <= e_d;
            f_q     <= f_d;
            enb_q   <= enb_d;
            h_q     <= h_d;
        end
    end

    assign e     = e_q;
    assign f     = f_q;
    assign h     = h_q;
    assign enb   = enb_q;
    assign state = state_q;

endmodule
